bank_scheduler: RTL and testbench

Per-bank front-end of the memory controller: accepts decoded requests, groups them by row into per-type FIFOs (read and write), and issues them one at a time to the downstream arbiter. Row-hit grouping happens at insertion: each FIFO holds only requests to one row. Draining follows the read/write mode chosen by the controller, using round-robin across FIFOs with a burst cap.

---
 rtl/bank_sched_pkg.sv | 22 ++
 rtl/row_fifo.sv | 68 ++++++
 rtl/bank_scheduler.sv | 174 +++++++++++++++++
 tb/tb_bank_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bank_sched_pkg.sv
// Shared widths, request-type encoding and FIFO entry layouts for the per-bank scheduler.
package bank_sched_pkg;
  localparam int RA_W    = 16;
  localparam int DATA_W  = 16;
  localparam int INDEX_W = 7;

  typedef enum logic {
    WRITE = 1'b0,
    READ  = 1'b1
  } req_type_e;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic [RA_W-1:0]    row;
  } rd_entry_t;

  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic [DATA_W-1:0]  data;
    logic [RA_W-1:0]    row;
  } wr_entry_t;
endpackage

// File: rtl/row_fifo.sv
// Small circular FIFO that also remembers the row of its most recent push,
// so the top can steer same-row requests into it.
module row_fifo #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 4,
  parameter int ADDR_BITS = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 push_i,
  input  logic                 pop_i,
  input  logic [WIDTH-1:0]     data_i,
  input  logic [ADDR_BITS-1:0] addr_i,
  output logic [WIDTH-1:0]     data_o,
  output logic                 empty_o,
  output logic                 full_o,
  output logic                 mid_o,
  output logic [ADDR_BITS-1:0] last_addr_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic [ADDR_BITS-1:0] last_addr_q, last_addr_d;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_comb begin
    wr_ptr_d    = push_i ? wrap_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d    = pop_i ? wrap_inc(rd_ptr_q) : rd_ptr_q;
    last_addr_d = push_i ? addr_i : last_addr_q;
    count_d     = count_q;
    if (push_i && !pop_i) count_d = count_q + CNT_W'(1);
    else if (pop_i && !push_i) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      last_addr_q <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      last_addr_q <= last_addr_d;
    end
  end

  // Storage needs no reset: the occupancy count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o      = mem_q[rd_ptr_q];
  assign empty_o     = (count_q == '0);
  assign full_o      = (count_q == CNT_W'(DEPTH));
  assign mid_o       = !empty_o && !full_o;
  assign last_addr_o = last_addr_q;

  assert property (@(posedge clk) disable iff (rst) !(pop_i && empty_o));
  assert property (@(posedge clk) disable iff (rst) !(push_i && full_o && !pop_i));
endmodule

// File: rtl/bank_scheduler.sv
// Per-bank front end: steers requests into row-grouped read/write FIFOs and
// drains the mode-selected type round-robin with a per-FIFO burst cap.
module bank_scheduler
  import bank_sched_pkg::*;
#(
  parameter int RA_BITS     = RA_W,
  parameter int DATA_BITS   = DATA_W,
  parameter int INDEX_BITS  = INDEX_W,
  parameter int ARR_NUM_RD  = 4,
  parameter int ARR_SIZE_RD = 4,
  parameter int ARR_NUM_WR  = 3,
  parameter int ARR_SIZE_WR = 2,
  parameter int BURST_MAX   = 4
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             valid_i,
  input  logic                             type_i,
  input  logic [RA_BITS-1:0]               row_i,
  input  logic [DATA_BITS-1:0]             data_i,
  input  logic [INDEX_BITS-1:0]            index_i,
  output logic                             ready_o,
  input  logic                             mode_i,
  input  logic                             arb_ready_i,
  output logic                             valid_o,
  output logic                             type_o,
  output logic [RA_BITS-1:0]               row_o,
  output logic [DATA_BITS-1:0]             data_o,
  output logic [INDEX_BITS-1:0]            index_o,
  output logic [ARR_NUM_RD+ARR_NUM_WR-1:0] buf_nonempty_o
);
  localparam int RD_W    = (ARR_NUM_RD > 1) ? $clog2(ARR_NUM_RD) : 1;
  localparam int WR_W    = (ARR_NUM_WR > 1) ? $clog2(ARR_NUM_WR) : 1;
  localparam int BURST_W = $clog2(BURST_MAX + 1);

  rd_entry_t rd_in, rd_head [ARR_NUM_RD];
  wr_entry_t wr_in, wr_head [ARR_NUM_WR];
  logic [ARR_NUM_RD-1:0] rd_push, rd_pop, rd_empty, rd_full, rd_mid, rd_nonempty;
  logic [ARR_NUM_WR-1:0] wr_push, wr_pop, wr_empty, wr_full, wr_mid, wr_nonempty;
  logic [RA_BITS-1:0]    rd_last [ARR_NUM_RD];
  logic [RA_BITS-1:0]    wr_last [ARR_NUM_WR];

  assign rd_in = '{index: index_i, row: row_i};
  assign wr_in = '{index: index_i, data: data_i, row: row_i};

  for (genvar g = 0; g < ARR_NUM_RD; g++) begin : g_rd
    row_fifo #(.WIDTH($bits(rd_entry_t)), .DEPTH(ARR_SIZE_RD), .ADDR_BITS(RA_BITS)) u_fifo (
      .clk(clk), .rst(rst_n), .push_i(rd_push[g]), .pop_i(rd_pop[g]), .data_i(rd_in),
      .addr_i(row_i), .data_o(rd_head[g]), .empty_o(rd_empty[g]), .full_o(rd_full[g]),
      .mid_o(rd_mid[g]), .last_addr_o(rd_last[g]));
  end

  for (genvar g = 0; g < ARR_NUM_WR; g++) begin : g_wr
    row_fifo #(.WIDTH($bits(wr_entry_t)), .DEPTH(ARR_SIZE_WR), .ADDR_BITS(RA_BITS)) u_fifo (
      .clk(clk), .rst(rst_n), .push_i(wr_push[g]), .pop_i(wr_pop[g]), .data_i(wr_in),
      .addr_i(row_i), .data_o(wr_head[g]), .empty_o(wr_empty[g]), .full_o(wr_full[g]),
      .mid_o(wr_mid[g]), .last_addr_o(wr_last[g]));
  end

  assign rd_nonempty    = ~rd_empty;
  assign wr_nonempty    = ~wr_empty;
  assign buf_nonempty_o = {wr_nonempty, rd_nonempty};

  // Insertion target: downward scan leaves the lowest-index row hit / empty slot.
  logic            rd_hit_ok, rd_emp_ok, wr_hit_ok, wr_emp_ok, rd_tgt_ok, wr_tgt_ok;
  logic [RD_W-1:0] rd_hit_idx, rd_emp_idx, rd_tgt;
  logic [WR_W-1:0] wr_hit_idx, wr_emp_idx, wr_tgt;

  always_comb begin
    rd_hit_ok = 1'b0; rd_hit_idx = '0; rd_emp_ok = 1'b0; rd_emp_idx = '0;
    wr_hit_ok = 1'b0; wr_hit_idx = '0; wr_emp_ok = 1'b0; wr_emp_idx = '0;
    for (int i = ARR_NUM_RD - 1; i >= 0; i--) begin
      if (rd_mid[i] && (rd_last[i] == row_i)) begin rd_hit_ok = 1'b1; rd_hit_idx = RD_W'(i); end
      if (rd_empty[i]) begin rd_emp_ok = 1'b1; rd_emp_idx = RD_W'(i); end
    end
    for (int i = ARR_NUM_WR - 1; i >= 0; i--) begin
      if (wr_mid[i] && (wr_last[i] == row_i)) begin wr_hit_ok = 1'b1; wr_hit_idx = WR_W'(i); end
      if (wr_empty[i]) begin wr_emp_ok = 1'b1; wr_emp_idx = WR_W'(i); end
    end
  end

  assign rd_tgt_ok = rd_hit_ok || rd_emp_ok;
  assign wr_tgt_ok = wr_hit_ok || wr_emp_ok;
  assign rd_tgt    = rd_hit_ok ? rd_hit_idx : rd_emp_idx;
  assign wr_tgt    = wr_hit_ok ? wr_hit_idx : wr_emp_idx;
  assign ready_o   = (type_i == READ) ? rd_tgt_ok : wr_tgt_ok;

  always_comb begin
    rd_push = '0;
    wr_push = '0;
    if (valid_i && ready_o) begin
      if (type_i == READ) rd_push[rd_tgt] = 1'b1;
      else wr_push[wr_tgt] = 1'b1;
    end
  end

  // Round-robin candidate: first non-empty FIFO after current, wrapping back onto it.
  logic [RD_W-1:0]    rd_cur_q, rd_cur_d, rd_cand, rd_rr_idx, rd_pick;
  logic [WR_W-1:0]    wr_cur_q, wr_cur_d, wr_cand, wr_rr_idx, wr_pick;
  logic [BURST_W-1:0] rd_burst_q, rd_burst_d, wr_burst_q, wr_burst_d;
  logic               rd_keep, wr_keep;

  always_comb begin
    rd_cand = '0; rd_rr_idx = rd_cur_q;
    wr_cand = '0; wr_rr_idx = wr_cur_q;
    for (int k = ARR_NUM_RD; k >= 1; k--) begin
      rd_cand = RD_W'((int'(rd_cur_q) + k) % ARR_NUM_RD);
      if (rd_nonempty[rd_cand]) rd_rr_idx = rd_cand;
    end
    for (int k = ARR_NUM_WR; k >= 1; k--) begin
      wr_cand = WR_W'((int'(wr_cur_q) + k) % ARR_NUM_WR);
      if (wr_nonempty[wr_cand]) wr_rr_idx = wr_cand;
    end
  end

  assign rd_keep = rd_nonempty[rd_cur_q] && (rd_burst_q < BURST_W'(BURST_MAX));
  assign wr_keep = wr_nonempty[wr_cur_q] && (wr_burst_q < BURST_W'(BURST_MAX));
  assign rd_pick = rd_keep ? rd_cur_q : rd_rr_idx;
  assign wr_pick = wr_keep ? wr_cur_q : wr_rr_idx;

  logic                  valid_q, valid_d, type_q, type_d, load_op;
  logic [RA_BITS-1:0]    row_q, row_d;
  logic [DATA_BITS-1:0]  data_q, data_d;
  logic [INDEX_BITS-1:0] index_q, index_d;

  assign load_op = !valid_q || arb_ready_i;

  always_comb begin
    rd_pop = '0; rd_cur_d = rd_cur_q; rd_burst_d = rd_burst_q;
    wr_pop = '0; wr_cur_d = wr_cur_q; wr_burst_d = wr_burst_q;
    valid_d = valid_q; type_d = type_q; row_d = row_q; data_d = data_q; index_d = index_q;
    if (load_op) begin
      valid_d = 1'b0;
      if (mode_i == READ && |rd_nonempty) begin
        rd_pop[rd_pick] = 1'b1;
        rd_cur_d   = rd_pick;
        rd_burst_d = (rd_keep ? rd_burst_q : '0) + BURST_W'(1);
        valid_d    = 1'b1;
        type_d     = READ;
        row_d      = rd_head[rd_pick].row;
        data_d     = '0;
        index_d    = rd_head[rd_pick].index;
      end else if (mode_i == WRITE && |wr_nonempty) begin
        wr_pop[wr_pick] = 1'b1;
        wr_cur_d   = wr_pick;
        wr_burst_d = (wr_keep ? wr_burst_q : '0) + BURST_W'(1);
        valid_d    = 1'b1;
        type_d     = WRITE;
        row_d      = wr_head[wr_pick].row;
        data_d     = wr_head[wr_pick].data;
        index_d    = wr_head[wr_pick].index;
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      rd_cur_q <= '0; rd_burst_q <= '0; wr_cur_q <= '0; wr_burst_q <= '0;
      valid_q  <= 1'b0; type_q <= 1'b0; row_q <= '0; data_q <= '0; index_q <= '0;
    end else begin
      rd_cur_q <= rd_cur_d; rd_burst_q <= rd_burst_d; wr_cur_q <= wr_cur_d; wr_burst_q <= wr_burst_d;
      valid_q  <= valid_d; type_q <= type_d; row_q <= row_d; data_q <= data_d; index_q <= index_d;
    end
  end

  assign valid_o = valid_q;
  assign type_o  = type_q;
  assign row_o   = row_q;
  assign data_o  = data_q;
  assign index_o = index_q;

  assert property (@(posedge clk) disable iff (rst_n)
    ((rd_push & rd_full) == '0) && ((wr_push & wr_full) == '0));
endmodule

// File: tb/tb_bank_scheduler.sv
// Directed self-checking bench for bank_scheduler: insertion grouping, mode gating,
// round-robin drain with burst cap, and asynchronous reset.
module tb_bank_scheduler;
  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  logic        clk = 1'b0;
  logic        rst_n, valid_i, type_i, mode_i, arb_ready_i;
  logic [15:0] row_i, data_i;
  logic [6:0]  index_i;
  logic        ready_o, valid_o, type_o;
  logic [15:0] row_o, data_o;
  logic [6:0]  index_o;
  logic [6:0]  buf_nonempty_o;

  int checks = 0;
  int failures = 0;

  logic [15:0] got_row[$];
  logic [15:0] got_data[$];
  logic [6:0]  got_idx[$];
  logic        got_type[$];

  bank_scheduler dut (
    .clk(clk), .rst_n(rst_n), .valid_i(valid_i), .type_i(type_i), .row_i(row_i),
    .data_i(data_i), .index_i(index_i), .ready_o(ready_o), .mode_i(mode_i),
    .arb_ready_i(arb_ready_i), .valid_o(valid_o), .type_o(type_o), .row_o(row_o),
    .data_o(data_o), .index_o(index_o), .buf_nonempty_o(buf_nonempty_o)
  );

  always #5 clk = ~clk;

  // Records every output the arbiter consumes on the coming edge, then advances one cycle.
  task automatic tick();
    #1;
    if (valid_o && arb_ready_i) begin
      got_row.push_back(row_o);
      got_data.push_back(data_o);
      got_idx.push_back(index_o);
      got_type.push_back(type_o);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic push_req(input logic t, input logic [15:0] r, input logic [15:0] d, input logic [6:0] ix);
    valid_i = 1'b1; type_i = t; row_i = r; data_i = d; index_i = ix;
    tick();
    valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b1; valid_i = 1'b0; type_i = RD; row_i = '0; data_i = '0; index_i = '0;
    mode_i = RD; arb_ready_i = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    got_row.delete(); got_data.delete(); got_idx.delete(); got_type.delete();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (valid_o !== 1'b0 || type_o !== 1'b0 || row_o !== 16'h0 || data_o !== 16'h0 || index_o !== 7'h0) begin
      failures++;
      $display("[TB] FAIL reset_outputs: got v=%b t=%b row=%h data=%h idx=%h, expected all zero",
               valid_o, type_o, row_o, data_o, index_o);
    end
    checks++;
    if (buf_nonempty_o !== 7'b0) begin
      failures++; $display("[TB] FAIL reset_buf: got %b expected %b", buf_nonempty_o, 7'b0);
    end
    #1;
    checks++;
    if (ready_o !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_ready_rd: got %b expected 1", ready_o);
    end
    type_i = WR; #1;
    checks++;
    if (ready_o !== 1'b1) begin
      failures++; $display("[TB] FAIL reset_ready_wr: got %b expected 1", ready_o);
    end
    type_i = RD;
  endtask

  task automatic test_first_read();
    do_reset();
    valid_i = 1'b1; type_i = RD; row_i = 16'h1234; index_i = 7'd5; #1;
    checks++;
    if (ready_o !== 1'b1) begin
      failures++; $display("[TB] FAIL first_ready: got %b expected 1", ready_o);
    end
    tick();
    valid_i = 1'b0;
    checks++;
    if (valid_o !== 1'b0) begin
      failures++; $display("[TB] FAIL first_latency1: got valid %b expected 0", valid_o);
    end
    tick();
    checks++;
    if (valid_o !== 1'b1 || row_o !== 16'h1234 || index_o !== 7'd5 || type_o !== RD || data_o !== 16'h0) begin
      failures++;
      $display("[TB] FAIL first_issue: got v=%b row=%h idx=%0d t=%b data=%h expected v=1 row=1234 idx=5 t=1 data=0000",
               valid_o, row_o, index_o, type_o, data_o);
    end
    tick();
    checks++;
    if (valid_o !== 1'b0) begin
      failures++; $display("[TB] FAIL first_consumed: got valid %b expected 0", valid_o);
    end
  endtask

  task automatic test_row_grouping();
    logic [6:0]  exp_idx [4] = '{7'd1, 7'd2, 7'd3, 7'd4};
    logic [15:0] exp_row [4] = '{16'h00AA, 16'h00AA, 16'h00AA, 16'h00BB};
    do_reset();
    push_req(RD, 16'h00AA, 16'h0, 7'd1);
    push_req(RD, 16'h00AA, 16'h0, 7'd2);
    push_req(RD, 16'h00AA, 16'h0, 7'd3);
    push_req(RD, 16'h00BB, 16'h0, 7'd4);
    checks++;
    if (buf_nonempty_o !== 7'b0000010) begin
      failures++; $display("[TB] FAIL group_buf: got %b expected %b", buf_nonempty_o, 7'b0000010);
    end
    repeat (6) tick();
    checks++;
    if (got_idx.size() != 4) begin
      failures++; $display("[TB] FAIL group_count: got %0d expected 4", got_idx.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_idx.size() || got_idx[i] !== exp_idx[i] || got_row[i] !== exp_row[i]) begin
        failures++;
        $display("[TB] FAIL group_order[%0d]: got idx=%0d row=%h expected idx=%0d row=%h",
                 i, got_idx[i], got_row[i], exp_idx[i], exp_row[i]);
      end
    end
  endtask

  task automatic test_full_fifo();
    do_reset();
    mode_i = WR; arb_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push_req(RD, 16'h0007, 16'h0, 7'(i));
    valid_i = 1'b1; type_i = RD; row_i = 16'h0007; index_i = 7'd4; #1;
    checks++;
    if (ready_o !== 1'b1) begin
      failures++; $display("[TB] FAIL full_ready: got %b expected 1", ready_o);
    end
    tick();
    valid_i = 1'b0;
    checks++;
    if (buf_nonempty_o !== 7'b0000011 || valid_o !== 1'b0) begin
      failures++;
      $display("[TB] FAIL full_spill: got buf=%b valid=%b expected buf=0000011 valid=0", buf_nonempty_o, valid_o);
    end
    mode_i = RD; arb_ready_i = 1'b1;
    repeat (8) tick();
    checks++;
    if (got_idx.size() != 5) begin
      failures++; $display("[TB] FAIL full_count: got %0d expected 5", got_idx.size());
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (i >= got_idx.size() || got_idx[i] !== 7'(i) || got_row[i] !== 16'h0007) begin
        failures++;
        $display("[TB] FAIL full_order[%0d]: got idx=%0d row=%h expected idx=%0d row=0007", i, got_idx[i], got_row[i], i);
      end
    end
  endtask

  task automatic test_no_free_fifo();
    do_reset();
    mode_i = WR; arb_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) push_req(RD, 16'h0010 + 16'(i), 16'h0, 7'(i));
    valid_i = 1'b1; type_i = RD; row_i = 16'h0014; index_i = 7'd4; #1;
    checks++;
    if (ready_o !== 1'b0) begin
      failures++; $display("[TB] FAIL nofree_ready: got %b expected 0", ready_o);
    end
    type_i = WR; #1;
    checks++;
    if (ready_o !== 1'b1) begin
      failures++; $display("[TB] FAIL nofree_wr_ready: got %b expected 1", ready_o);
    end
    type_i = RD;
    tick();
    valid_i = 1'b0;
    checks++;
    if (buf_nonempty_o !== 7'b0001111) begin
      failures++; $display("[TB] FAIL nofree_buf: got %b expected %b", buf_nonempty_o, 7'b0001111);
    end
    mode_i = RD; arb_ready_i = 1'b1;
    repeat (8) tick();
    checks++;
    if (got_idx.size() != 4) begin
      failures++; $display("[TB] FAIL nofree_count: got %0d expected 4", got_idx.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_row.size() || got_row[i] !== 16'h0010 + 16'(i)) begin
        failures++; $display("[TB] FAIL nofree_order[%0d]: got row=%h expected %h", i, got_row[i], 16'h0010 + 16'(i));
      end
    end
  endtask

  task automatic test_mode_gating();
    logic [6:0]  exp_idx  [4] = '{7'd10, 7'd12, 7'd11, 7'd13};
    logic [15:0] exp_row  [4] = '{16'h0020, 16'h0020, 16'h0021, 16'h0020};
    logic [15:0] exp_data [4] = '{16'hD0D0, 16'hD2D2, 16'hD1D1, 16'hD3D3};
    do_reset();
    push_req(WR, 16'h0020, 16'hD0D0, 7'd10);
    push_req(WR, 16'h0021, 16'hD1D1, 7'd11);
    push_req(WR, 16'h0020, 16'hD2D2, 7'd12);
    push_req(WR, 16'h0020, 16'hD3D3, 7'd13);
    repeat (3) tick();
    checks++;
    if (valid_o !== 1'b0 || got_idx.size() != 0) begin
      failures++; $display("[TB] FAIL gate_no_issue: got valid=%b issued=%0d expected 0/0", valid_o, got_idx.size());
    end
    checks++;
    if (buf_nonempty_o !== 7'b1110000) begin
      failures++; $display("[TB] FAIL gate_buf: got %b expected %b", buf_nonempty_o, 7'b1110000);
    end
    mode_i = WR;
    repeat (7) tick();
    checks++;
    if (got_idx.size() != 4) begin
      failures++; $display("[TB] FAIL gate_count: got %0d expected 4", got_idx.size());
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_idx.size() || got_idx[i] !== exp_idx[i] || got_row[i] !== exp_row[i] ||
          got_data[i] !== exp_data[i] || got_type[i] !== WR) begin
        failures++;
        $display("[TB] FAIL gate_order[%0d]: got idx=%0d row=%h data=%h t=%b expected idx=%0d row=%h data=%h t=0",
                 i, got_idx[i], got_row[i], got_data[i], got_type[i], exp_idx[i], exp_row[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_burst_cap();
    logic [15:0] exp_row [8] = '{16'h00A0, 16'h00A0, 16'h00A0, 16'h00A0,
                                 16'h00B0, 16'h00B0, 16'h00A0, 16'h00A0};
    do_reset();
    mode_i = WR;
    for (int i = 0; i < 4; i++) push_req(RD, 16'h00A0, 16'h0, 7'(i));
    push_req(RD, 16'h00B0, 16'h0, 7'd4);
    push_req(RD, 16'h00B0, 16'h0, 7'd5);
    checks++;
    if (buf_nonempty_o !== 7'b0000011) begin
      failures++; $display("[TB] FAIL burst_fill: got %b expected %b", buf_nonempty_o, 7'b0000011);
    end
    mode_i = RD;
    tick();
    push_req(RD, 16'h00A0, 16'h0, 7'd6);
    push_req(RD, 16'h00A0, 16'h0, 7'd7);
    repeat (10) tick();
    checks++;
    if (got_idx.size() != 8) begin
      failures++; $display("[TB] FAIL burst_count: got %0d expected 8", got_idx.size());
    end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (i >= got_idx.size() || got_idx[i] !== 7'(i) || got_row[i] !== exp_row[i]) begin
        failures++;
        $display("[TB] FAIL burst_order[%0d]: got idx=%0d row=%h expected idx=%0d row=%h",
                 i, got_idx[i], got_row[i], i, exp_row[i]);
      end
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    arb_ready_i = 1'b0;
    push_req(RD, 16'h0055, 16'h0, 7'd1);
    push_req(RD, 16'h0055, 16'h0, 7'd2);
    checks++;
    if (valid_o !== 1'b1 || buf_nonempty_o !== 7'b0000001) begin
      failures++; $display("[TB] FAIL midrst_pre: got valid=%b buf=%b expected 1/0000001", valid_o, buf_nonempty_o);
    end
    rst_n = 1'b1; #1;
    checks++;
    if (valid_o !== 1'b0 || buf_nonempty_o !== 7'b0 || ready_o !== 1'b1) begin
      failures++;
      $display("[TB] FAIL midrst_async: got valid=%b buf=%b ready=%b expected 0/0000000/1", valid_o, buf_nonempty_o, ready_o);
    end
    @(posedge clk);
    #1 rst_n = 1'b0;
    arb_ready_i = 1'b1;
    repeat (4) tick();
    checks++;
    if (got_idx.size() != 0 || valid_o !== 1'b0) begin
      failures++; $display("[TB] FAIL midrst_discard: got issued=%0d valid=%b expected 0/0", got_idx.size(), valid_o);
    end
  endtask

  initial begin
    test_reset();
    test_first_read();
    test_row_grouping();
    test_full_fifo();
    test_no_free_fifo();
    test_mode_gating();
    test_burst_cap();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
